// File: rtl/ysyx_rob_mc.sv
// ysyx_rob_mc: re-order buffer with register rename status.
// Takes one in-order dispatch and NWB out-of-order writebacks per cycle.
// Retires up to NCM finished entries per cycle and forwards operands to dispatch.
module ysyx_rob_mc #(
   parameter int ROB_SIZE = 8,
   parameter int NWB      = 2,
   parameter int NCM      = 2,
   parameter int REG_NUM  = 32,
   parameter int XLEN     = 32,
   localparam int TAGW    = $clog2(ROB_SIZE),
   localparam int REG_LEN = $clog2(REG_NUM)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush_pipe,
   input  logic                    sq_ready,
   input  logic                    disp_valid,
   output logic                    disp_ready,
   input  logic [REG_LEN-1:0]      disp_rd,
   input  logic [XLEN-1:0]         disp_pc,
   input  logic [XLEN-1:0]         disp_pnpc,
   input  logic                    disp_store,
   input  logic                    disp_trap,
   output logic [TAGW-1:0]         disp_tag,
   input  logic [REG_LEN-1:0]      rs1,
   input  logic [REG_LEN-1:0]      rs2,
   output logic                    rs1_busy,
   output logic                    rs1_ready,
   output logic [TAGW-1:0]         rs1_tag,
   output logic [XLEN-1:0]         rs1_value,
   output logic                    rs2_busy,
   output logic                    rs2_ready,
   output logic [TAGW-1:0]         rs2_tag,
   output logic [XLEN-1:0]         rs2_value,
   input  logic [NWB-1:0]          wb_valid,
   input  logic [NWB*TAGW-1:0]     wb_tag,
   input  logic [NWB*XLEN-1:0]     wb_value,
   input  logic [NWB*XLEN-1:0]     wb_npc,
   output logic [NCM-1:0]          cm_valid,
   output logic [NCM*REG_LEN-1:0]  cm_rd,
   output logic [NCM*XLEN-1:0]     cm_value,
   output logic [NCM*XLEN-1:0]     cm_pc,
   output logic [NCM-1:0]          cm_store,
   output logic                    cm_flush,
   output logic [XLEN-1:0]         cm_flush_npc,
   output logic [TAGW:0]           count
);

   typedef enum logic {ST_EX, ST_WB} state_e;

   logic                busy_q    [ROB_SIZE];
   state_e              state_q   [ROB_SIZE];
   logic [REG_LEN-1:0]  rd_q      [ROB_SIZE];
   logic [XLEN-1:0]     pc_q      [ROB_SIZE];
   logic [XLEN-1:0]     pnpc_q    [ROB_SIZE];
   logic [XLEN-1:0]     value_q   [ROB_SIZE];
   logic [XLEN-1:0]     npc_q     [ROB_SIZE];
   logic                store_q   [ROB_SIZE];
   logic                trap_q    [ROB_SIZE];
   logic [TAGW-1:0]     rmt_q     [REG_NUM];
   logic                rfBusy_q  [REG_NUM];
   logic [TAGW-1:0]     head_q, head_d;
   logic [TAGW-1:0]     tail_q, tail_d;
   logic [TAGW:0]       count_q, count_d;

   logic                fire;
   logic [TAGW:0]       nCommit;
   logic [TAGW-1:0]     cmTag     [NCM];
   logic [TAGW-1:0]     slotIdx;
   logic                slotOpen;
   logic                storeSeen;

   logic                srcBusy   [2];
   logic                srcReady  [2];
   logic [TAGW-1:0]     srcTag    [2];
   logic [XLEN-1:0]     srcValue  [2];
   logic [REG_LEN-1:0]  rsSel;
   logic [TAGW-1:0]     rsTag;

   assign disp_ready = (count_q != (TAGW+1)'(ROB_SIZE)) && !flush_pipe && !cm_flush;
   assign fire       = disp_valid & disp_ready;
   assign disp_tag   = tail_q;
   assign count      = count_q;

   assign head_d  = head_q + nCommit[TAGW-1:0];
   assign tail_d  = tail_q + {{(TAGW-1){1'b0}}, fire};
   assign count_d = count_q + {{TAGW{1'b0}}, fire} - nCommit;

   // In-order retirement: each slot needs the one below it retired, a finished entry, and store-queue room for a single store; a redirecting slot ends the group.
   always_comb begin
      cm_valid     = '0;
      cm_rd        = '0;
      cm_value     = '0;
      cm_pc        = '0;
      cm_store     = '0;
      cm_flush     = 1'b0;
      cm_flush_npc = '0;
      nCommit      = '0;
      slotIdx      = '0;
      slotOpen     = 1'b1;
      storeSeen    = 1'b0;
      for (int k = 0; k < NCM; k++) begin
         slotIdx  = head_q + TAGW'(k);
         cmTag[k] = slotIdx;
         cm_rd[k*REG_LEN +: REG_LEN] = rd_q[slotIdx];
         cm_value[k*XLEN +: XLEN]    = value_q[slotIdx];
         cm_pc[k*XLEN +: XLEN]       = pc_q[slotIdx];
         if (slotOpen && busy_q[slotIdx] && (state_q[slotIdx] == ST_WB) &&
             (!store_q[slotIdx] || (sq_ready && !storeSeen))) begin
            cm_valid[k] = 1'b1;
            cm_store[k] = store_q[slotIdx];
            nCommit     = nCommit + {{TAGW{1'b0}}, 1'b1};
            storeSeen   = storeSeen | store_q[slotIdx];
            if ((npc_q[slotIdx] != pnpc_q[slotIdx]) || trap_q[slotIdx]) begin
               cm_flush     = 1'b1;
               cm_flush_npc = npc_q[slotIdx];
               slotOpen     = 1'b0;
            end
         end else begin
            slotOpen = 1'b0;
         end
      end
   end

   // Source operand lookup: finished entries forward their stored value, otherwise the lowest writeback port hitting the producing tag bypasses.
   always_comb begin
      rsSel = '0;
      rsTag = '0;
      for (int s = 0; s < 2; s++) begin
         srcBusy[s]  = 1'b0;
         srcReady[s] = 1'b0;
         srcTag[s]   = '0;
         srcValue[s] = '0;
         rsSel = (s == 0) ? rs1 : rs2;
         if ((rsSel != '0) && rfBusy_q[rsSel]) begin
            rsTag      = rmt_q[rsSel];
            srcBusy[s] = 1'b1;
            srcTag[s]  = rsTag;
            if (state_q[rsTag] == ST_WB) begin
               srcReady[s] = 1'b1;
               srcValue[s] = value_q[rsTag];
            end else begin
               for (int i = NWB - 1; i >= 0; i--) begin
                  if (wb_valid[i] && (wb_tag[i*TAGW +: TAGW] == rsTag)) begin
                     srcReady[s] = 1'b1;
                     srcValue[s] = wb_value[i*XLEN +: XLEN];
                  end
               end
            end
         end
      end
   end

   assign rs1_busy  = srcBusy[0];
   assign rs1_ready = srcReady[0];
   assign rs1_tag   = srcTag[0];
   assign rs1_value = srcValue[0];
   assign rs2_busy  = srcBusy[1];
   assign rs2_ready = srcReady[1];
   assign rs2_tag   = srcTag[1];
   assign rs2_value = srcValue[1];

   // Buffer state: any flush empties everything; otherwise writebacks land, retired entries free up, then the dispatch allocates and renames.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int e = 0; e < ROB_SIZE; e++) begin
            busy_q[e]  <= 1'b0;
            state_q[e] <= ST_EX;
            rd_q[e]    <= '0;
            pc_q[e]    <= '0;
            pnpc_q[e]  <= '0;
            value_q[e] <= '0;
            npc_q[e]   <= '0;
            store_q[e] <= 1'b0;
            trap_q[e]  <= 1'b0;
         end
         for (int r = 0; r < REG_NUM; r++) begin
            rmt_q[r]    <= '0;
            rfBusy_q[r] <= 1'b0;
         end
      end else if (flush_pipe || cm_flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int e = 0; e < ROB_SIZE; e++) begin
            busy_q[e]  <= 1'b0;
            state_q[e] <= ST_EX;
         end
         for (int r = 0; r < REG_NUM; r++) begin
            rfBusy_q[r] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NWB; i++) begin
            if (wb_valid[i] && busy_q[wb_tag[i*TAGW +: TAGW]]) begin
               state_q[wb_tag[i*TAGW +: TAGW]] <= ST_WB;
               value_q[wb_tag[i*TAGW +: TAGW]] <= wb_value[i*XLEN +: XLEN];
               npc_q[wb_tag[i*TAGW +: TAGW]]   <= wb_npc[i*XLEN +: XLEN];
            end
         end
         for (int k = 0; k < NCM; k++) begin
            if (cm_valid[k]) begin
               busy_q[cmTag[k]]  <= 1'b0;
               state_q[cmTag[k]] <= ST_EX;
               if ((rd_q[cmTag[k]] != '0) && (rmt_q[rd_q[cmTag[k]]] == cmTag[k]) &&
                   !(fire && (disp_rd == rd_q[cmTag[k]]))) begin
                  rfBusy_q[rd_q[cmTag[k]]] <= 1'b0;
               end
            end
         end
         if (fire) begin
            busy_q[tail_q]  <= 1'b1;
            state_q[tail_q] <= ST_EX;
            rd_q[tail_q]    <= disp_rd;
            pc_q[tail_q]    <= disp_pc;
            pnpc_q[tail_q]  <= disp_pnpc;
            store_q[tail_q] <= disp_store;
            trap_q[tail_q]  <= disp_trap;
            if (disp_rd != '0) begin
               rmt_q[disp_rd]    <= tail_q;
               rfBusy_q[disp_rd] <= 1'b1;
            end
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule
